// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants: byte width, default FIFO geometry and MMIO status bit positions.
// The MMIO wrapper and the FIFO both import this, so status decode stays consistent.
package uart_rx_fifo_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int RX_DEPTH_LOG2  = 4;
  localparam int RX_AFULL_LEVEL = 12;

  // MMIO status register bit positions
  localparam int STAT_TX_READY   = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_RX_AFULL   = 2;
  localparam int STAT_RX_OVERRUN = 3;

  typedef struct packed {
    logic overrun;
    logic afull;
    logic rx_valid;
    logic tx_ready;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous (show-ahead) read port.
// No reset; contents are only meaningful where the owner's pointers say so.
module fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Elastic UART receive buffer with occupancy count, almost-full and sticky overrun flags.
// Show-ahead, 1-cycle write-to-read latency; in_ready/out_valid decode from the count register only.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = RX_DEPTH_LOG2,
  parameter int WIDTH       = UART_BYTE_W,
  parameter int AFULL_LEVEL = RX_AFULL_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  overrun
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Flags come from registered count only, so out_ready never reaches in_ready combinationally.
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    in_ready    = !full;
    out_valid   = (count_q != '0);
    almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (in_valid && full) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push & ~flush & ~reset),
    .wr_addr(wr_ptr_q),
    .wr_data(in_data),
    .rd_addr(rd_ptr_q),
    .rd_data(out_data)
  );

  assign count   = count_q;
  assign overrun = overrun_q;

endmodule
